// File: rtl/adpcm_tx_packer.sv
// Encode-side sequencer for the ADPCM codec: hands PCM samples to the codec via
// its toggle-request / ack-idle handshake and packs the returned codes two per byte.
module adpcm_tx_packer #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enable,
    input  logic [15:0]   s_pcm,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          flush,
    output logic [7:0]    m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          codec_req,
    output logic          codec_sel_rx,
    output logic [15:0]   codec_rx_pcm,
    input  logic          codec_ack,
    input  logic [3:0]    codec_tx_adpcm,
    output logic          half_pending,
    output logic [AW:0]   level,
    output logic          timeout_err
);
    localparam int          CW         = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, SETUP, FIRE, WAIT_LO, WAIT_HI, CAPTURE
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     pcm_q, pcm_d;
    logic            req_q, req_d;
    logic [3:0]      low_q, low_d;
    logic            half_q, half_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            terr_q, terr_d;
    logic            run_q, run_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]     level_q, level_d;
    logic            not_full, push, pop;
    logic [7:0]      push_byte;

    // run_q keeps s_ready low while reset is asserted and for the cycle it is released
    assign not_full     = (level_q != FULL_LEVEL);
    assign s_ready      = run_q && enable && (state_q == IDLE) && codec_ack && not_full;
    assign m_valid      = (level_q != '0);
    assign m_data       = mem_q[rd_q];
    assign pop          = m_valid && m_ready;
    assign codec_req    = req_q;
    assign codec_sel_rx = 1'b0;
    assign codec_rx_pcm = pcm_q;
    assign half_pending = half_q;
    assign level        = level_q;
    assign timeout_err  = terr_q;

    always_comb begin
        state_d   = state_q;
        pcm_d     = pcm_q;
        req_d     = req_q;
        low_d     = low_q;
        half_d    = half_q;
        cnt_d     = cnt_q;
        terr_d    = terr_q;
        run_d     = enable;
        push      = 1'b0;
        push_byte = '0;

        case (state_q)
            IDLE: begin
                // A coincident flush closes the old byte before the new sample is taken
                if (flush && half_q && not_full) begin
                    push      = 1'b1;
                    push_byte = {4'h0, low_q};
                    half_d    = 1'b0;
                end
                if (s_valid && s_ready) begin
                    pcm_d   = s_pcm;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = FIRE;
            FIRE: begin
                req_d   = ~req_q;
                cnt_d   = CW'(1);
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!codec_ack) begin
                    cnt_d   = CW'(1);
                    state_d = WAIT_HI;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HI: begin
                if (codec_ack) begin
                    state_d = CAPTURE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CAPTURE: begin
                if (!half_q) begin
                    low_d  = codec_tx_adpcm;
                    half_d = 1'b1;
                end else begin
                    push      = 1'b1;
                    push_byte = {codec_tx_adpcm, low_q};
                    half_d    = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (push) begin
            mem_d[wr_q] = push_byte;
            wr_d        = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase

        // Disabled block returns to its reset image; codec_req held low so no toggle on re-enable
        if (!enable) begin
            state_d = IDLE;
            pcm_d   = '0;
            req_d   = 1'b0;
            low_d   = '0;
            half_d  = 1'b0;
            cnt_d   = '0;
            terr_d  = 1'b0;
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            pcm_q   <= '0;
            req_q   <= 1'b0;
            low_q   <= '0;
            half_q  <= 1'b0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
            run_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pcm_q   <= pcm_d;
            req_q   <= req_d;
            low_q   <= low_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            run_q   <= run_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            mem_q   <= mem_d;
        end
    end
endmodule
